// File: rtl/a5_pkg.sv
// Shared state encoding and default sizing for the A5 program loader.
// Used by a5_prog_loader and a5_timeout_cnt.
package a5_pkg;

  localparam int A5_ADDR_W  = 12;
  localparam int A5_TIMEOUT = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_LOAD_LO,
    S_WRITE,
    S_CHK_HI,
    S_CHK_LO,
    S_DONE,
    S_ERROR
  } a5_state_e;

endpackage

// File: rtl/a5_timeout_cnt.sv
// Idle-cycle watchdog for the loader byte stream.
// hit_o fires on the TIMEOUT-th consecutive idle cycle.
module a5_timeout_cnt #(
  parameter int TIMEOUT = a5_pkg::A5_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign hit_o = inc_i && !clr_i &&
                 (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/a5_prog_loader.sv
// Byte-stream instruction-memory loader holding the core in reset.
// Define A5_LOADER_CHECKSUM_EN to require a trailing 16-bit sum.
module a5_prog_loader
  import a5_pkg::*;
#(
  parameter int ADDR_W  = A5_ADDR_W,
  parameter int TIMEOUT = A5_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] WORD_COUNT,
  input  logic              BYTE_VALID,
  input  logic [7:0]        BYTE_DATA,
  output logic              BYTE_READY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DATA,
  output logic              MEM_WE,
  output logic              CORE_RST,
  output logic              DONE,
  output logic              ERR
);

  a5_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wc_q;
  logic [15:0]       data_q;
  logic              ready_q;
  logic              we_q;
  logic              core_rst_q;
  logic              done_q;
  logic              err_q;
`ifdef A5_LOADER_CHECKSUM_EN
  logic [15:0]       sum_q;
  logic [7:0]        chk_hi_q;
`endif

  logic accept;
  logic tmo_hit;
  logic last_word;

  assign accept    = BYTE_VALID && ready_q;
  assign last_word = (addr_q == wc_q - ADDR_W'(1));

  a5_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (accept || !ready_q),
    .inc_i (ready_q),
    .hit_o (tmo_hit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wc_q       <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef A5_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      chk_hi_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (tmo_hit) begin
        state_q    <= S_ERROR;
        ready_q    <= 1'b0;
        err_q      <= 1'b1;
        core_rst_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE, S_ERROR: begin
            if (START) begin
              addr_q     <= '0;
              wc_q       <= WORD_COUNT;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              core_rst_q <= 1'b1;
`ifdef A5_LOADER_CHECKSUM_EN
              sum_q      <= '0;
`endif
              if (WORD_COUNT == '0) begin
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                core_rst_q <= 1'b0;
              end else begin
                state_q <= S_LOAD_HI;
                ready_q <= 1'b1;
              end
            end
          end
          S_LOAD_HI: begin
            if (accept) begin
              data_q[15:8] <= BYTE_DATA;
              state_q      <= S_LOAD_LO;
            end
          end
          S_LOAD_LO: begin
            if (accept) begin
              data_q[7:0] <= BYTE_DATA;
              state_q     <= S_WRITE;
              ready_q     <= 1'b0;
              we_q        <= 1'b1;
            end
          end
          S_WRITE: begin
`ifdef A5_LOADER_CHECKSUM_EN
            sum_q <= sum_q + data_q;
`endif
            if (last_word) begin
`ifdef A5_LOADER_CHECKSUM_EN
              state_q <= S_CHK_HI;
              ready_q <= 1'b1;
`else
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
`endif
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_LOAD_HI;
              ready_q <= 1'b1;
            end
          end
`ifdef A5_LOADER_CHECKSUM_EN
          S_CHK_HI: begin
            if (accept) begin
              chk_hi_q <= BYTE_DATA;
              state_q  <= S_CHK_LO;
            end
          end
          S_CHK_LO: begin
            if (accept) begin
              ready_q <= 1'b0;
              if ({chk_hi_q, BYTE_DATA} == sum_q) begin
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                core_rst_q <= 1'b0;
              end else begin
                state_q    <= S_ERROR;
                err_q      <= 1'b1;
                core_rst_q <= 1'b1;
              end
            end
          end
`endif
          default: begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign BYTE_READY = ready_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_DATA   = data_q;
  assign MEM_WE     = we_q;
  assign CORE_RST   = core_rst_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_a5_prog_loader.sv
// Scoreboard bench for a5_prog_loader.
// Expected writes are queued as bytes are driven.
module tb_a5_prog_loader;

  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [AW-1:0] WORD_COUNT = '0;
  logic          BYTE_VALID = 1'b0;
  logic [7:0]    BYTE_DATA = '0;
  logic          BYTE_READY;
  logic [AW-1:0] MEM_ADDR;
  logic [15:0]   MEM_DATA;
  logic          MEM_WE;
  logic          CORE_RST;
  logic          DONE;
  logic          ERR;

  a5_prog_loader #(
    .ADDR_W  (AW),
    .TIMEOUT (1000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .WORD_COUNT (WORD_COUNT),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_DATA  (BYTE_DATA),
    .BYTE_READY (BYTE_READY),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_DATA   (MEM_DATA),
    .MEM_WE     (MEM_WE),
    .CORE_RST   (CORE_RST),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_we = 1'b0;

`ifdef A5_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (MEM_WE) begin
      chk("we_1cyc", {31'd0, prev_we}, 32'd0);
      if (q.size() == 0) begin
        chk("we_unexp", {20'd0, MEM_ADDR}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("waddr", {20'd0, MEM_ADDR}, {20'd0, e.a});
        chk("wdata", {16'd0, MEM_DATA}, {16'd0, e.d});
      end
    end
    prev_we <= MEM_WE;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] wc);
    WORD_COUNT = wc;
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    int n;
    n = 0;
    BYTE_VALID = 1'b1;
    BYTE_DATA  = b;
    while (!BYTE_READY && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("rdy_to", n, 0);
    step();
    if (!keep) BYTE_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a,
                           input logic [15:0] w,
                           input bit keep);
    wr_t e;
    e.a = a;
    e.d = w;
    q.push_back(e);
    send(w[15:8], keep);
    send(w[7:0], keep);
  endtask

  task automatic wait_end(input int limit, output int n);
    n = 0;
    while (!(DONE || ERR) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) chk("end_to", n, 0);
  endtask

  task automatic check_end(input string tag, input bit ok);
    chk({tag, "_done"}, {31'd0, DONE}, {31'd0, ok});
    chk({tag, "_err"}, {31'd0, ERR}, {31'd0, !ok});
    chk({tag, "_crst"}, {31'd0, CORE_RST}, {31'd0, !ok});
    chk({tag, "_qempty"}, q.size(), 0);
  endtask

  initial begin
    int n;
    logic [15:0] w [3];
    logic [15:0] sum;

    step();
    chk("rst_crst", {31'd0, CORE_RST}, 32'd1);
    chk("rst_rdy", {31'd0, BYTE_READY}, 32'd0);
    chk("rst_we", {31'd0, MEM_WE}, 32'd0);
    chk("rst_addr", {20'd0, MEM_ADDR}, 32'd0);
    chk("rst_data", {16'd0, MEM_DATA}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    step();

    // Two-word load, good checksum.
    start(2);
    chk("ld_rdy", {31'd0, BYTE_READY}, 32'd1);
    chk("ld_crst", {31'd0, CORE_RST}, 32'd1);
    send_word(0, 16'h1234, 1'b0);
    send_word(1, 16'hABCD, 1'b0);
    if (CHK) begin
      send(8'hBE, 1'b0);
      send(8'h01, 1'b0);
    end
    wait_end(20, n);
    check_end("good", 1'b1);

    // Same load, bad checksum low byte.
    start(2);
    chk("restart_done", {31'd0, DONE}, 32'd0);
    send_word(0, 16'h1234, 1'b0);
    send_word(1, 16'hABCD, 1'b0);
    if (CHK) begin
      send(8'hBE, 1'b0);
      send(8'h02, 1'b0);
    end
    wait_end(20, n);
    check_end("badsum", !CHK);

    // Stall after the high byte until the watchdog trips.
    start(1);
    send(8'h55, 1'b0);
    wait_end(1100, n);
    chk("tmo_len_ok", {31'd0, (n >= 995 && n <= 1005)}, 32'd1);
    check_end("tmo", 1'b0);

    // Back-to-back stream with START held mid-load.
    w[0] = 16'h0102;
    w[1] = 16'h0304;
    w[2] = 16'h0506;
    sum = w[0] + w[1] + w[2];
    start(3);
    send_word(0, w[0], 1'b1);
    WORD_COUNT = 12'd9;
    START = 1'b1;
    send_word(1, w[1], 1'b1);
    START = 1'b0;
    send_word(2, w[2], CHK);
    if (CHK) begin
      send(sum[15:8], 1'b1);
      send(sum[7:0], 1'b0);
    end
    BYTE_VALID = 1'b0;
    wait_end(20, n);
    check_end("b2b", 1'b1);
    chk("b2b_addr", {20'd0, MEM_ADDR}, 32'd2);

    // Reset between the two bytes of the third word.
    start(4);
    send_word(0, 16'h1111, 1'b0);
    send_word(1, 16'h2222, 1'b0);
    send(8'h33, 1'b1);
    BYTE_DATA = 8'h44;
    RST = 1'b1;
    #1;
    chk("abort_crst", {31'd0, CORE_RST}, 32'd1);
    chk("abort_rdy", {31'd0, BYTE_READY}, 32'd0);
    chk("abort_we", {31'd0, MEM_WE}, 32'd0);
    step();
    step();
    RST = 1'b0;
    step();
    step();
    chk("abort_idle_rdy", {31'd0, BYTE_READY}, 32'd0);
    chk("abort_qempty", q.size(), 0);
    BYTE_VALID = 1'b0;

    // Zero-length load finishes without touching the stream.
    BYTE_VALID = 1'b1;
    BYTE_DATA  = 8'h99;
    start(0);
    chk("zero_done", {31'd0, DONE}, 32'd1);
    chk("zero_crst", {31'd0, CORE_RST}, 32'd0);
    chk("zero_rdy", {31'd0, BYTE_READY}, 32'd0);
    step();
    chk("zero_rdy2", {31'd0, BYTE_READY}, 32'd0);
    chk("zero_hold", {31'd0, DONE}, 32'd1);
    BYTE_VALID = 1'b0;
    step();
    chk("final_qempty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
